// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I sequencer: opcodes, FSM states and halt causes.
package rv_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Width of the fetch wait counter (FETCH_TIMEOUT legal range 1..255).
    localparam int unsigned TO_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        HC_NONE     = 2'b00,
        HC_ILLEGAL  = 2'b01,
        HC_MISALIGN = 2'b10,
        HC_TIMEOUT  = 2'b11
    } halt_cause_t;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_IMM) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/rv_seq_ctrl_if.sv
// Instruction-memory req/ack bus between the sequencer (master) and memory (slave).
interface rv_seq_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/rv_fetch_if.sv
// Fetch handshake: owns the registered imem_req and the wait/timeout counter.
module rv_fetch_if
    import rv_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_start,
    input  logic imem_ack,
    output logic imem_req,
    output logic fetch_done,
    output logic fetch_timeout
);

    localparam logic [TO_CNT_W-1:0] WAIT_LAST = TO_CNT_W'(FETCH_TIMEOUT - 1);

    logic [TO_CNT_W-1:0] wait_cnt;

    // wait_cnt holds the number of completed ack-less request cycles so far,
    // so the FETCH_TIMEOUT-th ack-less cycle is the one where it equals WAIT_LAST.
    assign fetch_done    = imem_req & imem_ack;
    assign fetch_timeout = imem_req & ~imem_ack & (wait_cnt == WAIT_LAST);

    // Request register and wait counter; ack outside a request is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req <= 1'b0;
            wait_cnt <= '0;
        end else if (fetch_start) begin
            imem_req <= 1'b1;
            wait_cnt <= '0;
        end else if (fetch_done) begin
            imem_req <= 1'b0;
            wait_cnt <= '0;
        end else if (imem_req) begin
            wait_cnt <= wait_cnt + TO_CNT_W'(1);
            if (fetch_timeout) begin
                imem_req <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle RV32I sequencer: PC, instruction latch, FETCH/DECODE/EXEC/HALT control.
module rv_seq_ctrl
    import rv_pkg::*;
#(
    parameter logic [31:0]  RESET_PC      = 32'h0000_0000,
    parameter int unsigned  FETCH_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rv_seq_ctrl_if.master      imem,
    output logic [31:0]        instr,
    input  logic [31:0]        imm,
    input  logic               br_taken,
    output logic               rf_we,
    output logic               retire,
    output logic [31:0]        pc,
    output logic [31:0]        retire_cnt,
    output logic               halted,
    output logic [1:0]         halt_cause
);

    state_t      state;
    halt_cause_t cause;

    logic        fetch_req;
    logic        fetch_start;
    logic        fetch_done;
    logic        fetch_timeout;

    logic        is_branch;
    logic [31:0] br_target;
    logic        exec_fault;
    logic [31:0] pc_next;

    assign is_branch  = (instr[6:0] == OP_BRANCH);
    assign br_target  = pc + imm;
    assign exec_fault = is_branch & br_taken & (br_target[1:0] != 2'b00);
    assign pc_next    = (is_branch && br_taken) ? br_target : pc + 32'd4;

    // A new fetch starts when leaving RST or on a successful EXEC, so imem_req
    // rises on the same edge the FSM enters FETCH.
    assign fetch_start = (state == ST_RST) || ((state == ST_EXEC) && !exec_fault);

    assign imem.imem_req  = fetch_req;
    assign imem.imem_addr = pc;
    assign halt_cause     = cause;

    rv_fetch_if #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_start   (fetch_start),
        .imem_ack      (imem.imem_ack),
        .imem_req      (fetch_req),
        .fetch_done    (fetch_done),
        .fetch_timeout (fetch_timeout)
    );

    // Sequencer FSM with registered strobes; retire and the pc/retire_cnt
    // updates all land on the edge that leaves EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RST;
            pc         <= RESET_PC;
            instr      <= '0;
            retire_cnt <= '0;
            rf_we      <= 1'b0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            cause      <= HC_NONE;
        end else begin
            rf_we  <= 1'b0;
            retire <= 1'b0;
            case (state)
                ST_RST: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (fetch_done) begin
                        instr <= imem.imem_rdata;
                        state <= ST_DECODE;
                    end else if (fetch_timeout) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                        cause  <= HC_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    if (is_supported(instr[6:0])) begin
                        state <= ST_EXEC;
                        rf_we <= (instr[6:0] == OP_IMM) && (instr[11:7] != 5'd0);
                    end else begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                        cause  <= HC_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    if (exec_fault) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                        cause  <= HC_MISALIGN;
                    end else begin
                        pc         <= pc_next;
                        retire     <= 1'b1;
                        retire_cnt <= retire_cnt + 32'd1;
                        state      <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Scoreboard bench for rv_seq_ctrl: directed programs, memory responder, retire/halt monitor.
module tb_rv_seq_ctrl;

    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        br_taken;
    logic        rf_we;
    logic        retire;
    logic [31:0] pc;
    logic [31:0] retire_cnt;
    logic        halted;
    logic [1:0]  halt_cause;

    rv_seq_ctrl_if bus ();

    rv_seq_ctrl #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (bus),
        .instr      (instr),
        .imm        (imm),
        .br_taken   (br_taken),
        .rf_we      (rf_we),
        .retire     (retire),
        .pc         (pc),
        .retire_cnt (retire_cnt),
        .halted     (halted),
        .halt_cause (halt_cause)
    );

    always #5 clk = ~clk;

    // Instruction memory, per-address ack delay, and per-pc branch outcome.
    logic [31:0] mem       [0:15];
    int          delay_tbl [0:15];
    logic        taken_tbl [0:15];
    logic        ack_q = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] rdata_q = 32'hDEAD_BEEF;
    int          waited = 0;

    function automatic logic [31:0] imm_of(input logic [31:0] i);
        if (i[6:0] == 7'b1100011)
            return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        return {{20{i[31]}}, i[31:20]};
    endfunction

    assign imm            = imm_of(instr);
    assign br_taken       = taken_tbl[pc[5:2]];
    assign bus.imem_ack   = ack_q | force_ack;
    assign bus.imem_rdata = rdata_q;

    // Memory responder: acks after delay_tbl[addr] ack-less request cycles.
    always @(negedge clk) begin
        if (!rst_n || !bus.imem_req) begin
            ack_q   = 1'b0;
            waited  = 0;
            rdata_q = 32'hDEAD_BEEF;
        end else if (waited >= delay_tbl[bus.imem_addr[5:2]]) begin
            ack_q   = 1'b1;
            rdata_q = mem[bus.imem_addr[5:2]];
        end else begin
            ack_q   = 1'b0;
            rdata_q = 32'hDEAD_BEEF;
            waited++;
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        we;
        int          gap;
    } ret_t;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] pc;
        logic [31:0] cnt;
    } halt_t;

    ret_t  ret_q  [$];
    halt_t halt_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on each retire pulse and on each halt entry.
    int   cyc = 0;
    int   last_ret = -1;
    logic we_seen = 1'b0;
    logic prev_halted = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        ret_t  r;
        halt_t h;
        if (!rst_n) begin
            last_ret    = -1;
            we_seen     = 1'b0;
            prev_halted = 1'b0;
        end else begin
            if (rf_we) we_seen = 1'b1;
            if (retire) begin
                checks++;
                if (ret_q.size() == 0) begin
                    errors++;
                    $display("FAIL retire_unexpected: retire at pc=%h cnt=%h, none expected", pc, retire_cnt);
                end else begin
                    r = ret_q.pop_front();
                    check32("retire_pc", pc, r.pc);
                    check32("retire_cnt", retire_cnt, r.cnt);
                    check32("retire_rf_we", {31'b0, we_seen}, {31'b0, r.we});
                    if (r.gap != 0)
                        check32("retire_gap", cyc - last_ret, r.gap);
                end
                last_ret = cyc;
                we_seen  = 1'b0;
            end
            if (halted && !prev_halted) begin
                checks++;
                if (halt_q.size() == 0) begin
                    errors++;
                    $display("FAIL halt_unexpected: halt cause=%b pc=%h, none expected", halt_cause, pc);
                end else begin
                    h = halt_q.pop_front();
                    check32("halt_cause", {30'b0, halt_cause}, {30'b0, h.cause});
                    check32("halt_pc", pc, h.pc);
                    check32("halt_cnt", retire_cnt, h.cnt);
                    check32("halt_req", {31'b0, bus.imem_req}, 32'd0);
                    check32("halt_rf_we", {31'b0, we_seen}, 32'd0);
                end
                we_seen = 1'b0;
            end
            prev_halted = halted;
        end
    end

    task automatic push_ret(input logic [31:0] p, input logic [31:0] c, input logic we, input int gap);
        ret_t r;
        r.pc = p; r.cnt = c; r.we = we; r.gap = gap;
        ret_q.push_back(r);
    endtask

    task automatic push_halt(input logic [1:0] cause, input logic [31:0] p, input logic [31:0] c);
        halt_t h;
        h.cause = cause; h.pc = p; h.cnt = c;
        halt_q.push_back(h);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((ret_q.size() != 0 || halt_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (ret_q.size() != 0 || halt_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d retires and %0d halts still pending after %0d cycles",
                     name, ret_q.size(), halt_q.size(), budget);
        end
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]       = 32'h0000_0033;
            delay_tbl[i] = 0;
            taken_tbl[i] = 1'b0;
        end
        mem[0] = 32'h0050_0093;   // addi x1,x0,5
        mem[1] = 32'h0000_0013;   // addi x0,x0,0
        mem[2] = 32'h0050_0113;   // addi x2,x0,5
        mem[3] = 32'h0000_0013;   // addi x0,x0,0
        mem[4] = 32'h0000_0463;   // beq x0,x0,+8
        mem[5] = 32'h0050_0193;   // addi x3,x0,5
        mem[6] = 32'h0000_0013;   // addi x0,x0,0
        mem[7] = 32'h0000_0033;   // add (unsupported opcode)
        taken_tbl[4] = 1'b1;

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        check32("rst_pc", pc, 32'h0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_retire_cnt", retire_cnt, 32'h0);
        check32("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        check32("rst_rf_we", {31'b0, rf_we}, 32'd0);
        check32("rst_retire", {31'b0, retire}, 32'd0);
        check32("rst_halted", {31'b0, halted}, 32'd0);
        check32("rst_halt_cause", {30'b0, halt_cause}, 32'd0);

        // Program 1: ALU ops, taken branch, then an illegal opcode.
        push_ret(32'h04, 32'd1, 1'b1, 0);
        push_ret(32'h08, 32'd2, 1'b0, 3);
        push_ret(32'h0C, 32'd3, 1'b1, 3);
        push_ret(32'h10, 32'd4, 1'b0, 3);
        push_ret(32'h18, 32'd5, 1'b0, 3);
        push_ret(32'h1C, 32'd6, 1'b0, 3);
        push_halt(2'b01, 32'h1C, 32'd6);
        release_reset();
        begin
            int n = 0;
            while (!bus.imem_req && n < 5) begin
                @(negedge clk);
                n++;
            end
        end
        check32("first_req", {31'b0, bus.imem_req}, 32'd1);
        check32("first_addr", bus.imem_addr, 32'h0);
        wait_drain("prog1", 200);

        // Acks arriving while halted must be ignored.
        force_ack = 1'b1;
        repeat (4) @(negedge clk);
        check32("halt_ack_req", {31'b0, bus.imem_req}, 32'd0);
        force_ack = 1'b0;
        @(negedge clk);
        check32("halt_frozen_instr", instr, 32'h0000_0033);
        check32("halt_frozen_pc", pc, 32'h1C);
        check32("halt_frozen_cnt", retire_cnt, 32'd6);
        check32("halt_sticky", {31'b0, halted}, 32'd1);

        // Program 2: not-taken branch, 15-cycle ack delay, then a fetch that never acks.
        enter_reset();
        taken_tbl[4] = 1'b0;
        delay_tbl[5] = 15;
        delay_tbl[6] = NEVER;
        push_ret(32'h04, 32'd1, 1'b1, 0);
        push_ret(32'h08, 32'd2, 1'b0, 3);
        push_ret(32'h0C, 32'd3, 1'b1, 3);
        push_ret(32'h10, 32'd4, 1'b0, 3);
        push_ret(32'h14, 32'd5, 1'b0, 3);
        push_ret(32'h18, 32'd6, 1'b1, 18);
        push_halt(2'b11, 32'h18, 32'd6);
        release_reset();
        wait_drain("prog2", 400);
        check32("timeout_req", {31'b0, bus.imem_req}, 32'd0);
        check32("timeout_halted", {31'b0, halted}, 32'd1);

        // Program 3: taken branch to pc+6 is misaligned.
        enter_reset();
        for (int i = 0; i < 16; i++) delay_tbl[i] = 0;
        mem[0]       = 32'h0000_0363;   // beq x0,x0,+6
        taken_tbl[0] = 1'b1;
        push_halt(2'b10, 32'h0, 32'd0);
        release_reset();
        wait_drain("prog3", 50);
        check32("misalign_instr", instr, 32'h0000_0363);

        // Reset asserted mid-FETCH: req drops at once, later acks ignored.
        enter_reset();
        mem[0]       = 32'h0050_0093;
        taken_tbl[0] = 1'b0;
        delay_tbl[0] = NEVER;
        release_reset();
        repeat (4) @(negedge clk);
        check32("midfetch_req_before", {31'b0, bus.imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check32("midfetch_req_async", {31'b0, bus.imem_req}, 32'd0);
        check32("midfetch_pc_async", pc, 32'h0);
        check32("midfetch_halted", {31'b0, halted}, 32'd0);
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        check32("midfetch_instr", instr, 32'h0);
        check32("midfetch_req_held", {31'b0, bus.imem_req}, 32'd0);
        force_ack    = 1'b0;
        delay_tbl[0] = 0;
        delay_tbl[1] = NEVER;
        push_ret(32'h04, 32'd1, 1'b1, 0);
        release_reset();
        wait_drain("after_reset", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
